// File: rtl/mod_up_counter.sv
// Loadable up counter with a runtime-programmable terminal value: wraps to 0 or
// holds at the limit, with a terminal-count output, a one-cycle wrap pulse and a sticky overflow flag.
module mod_up_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             sat_mode_i,
  input  logic             ovf_clr_i,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o,
  output logic             wrap_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             at_limit;
  logic             set_evt;

  // q >= limit also covers values loaded above the limit, so q+1 never overflows.
  assign at_limit = (q_q >= limit_i);

  always_comb begin
    q_d     = q_q;
    wrap_d  = 1'b0;
    set_evt = 1'b0;
    if (clr_i) begin
      q_d = '0;
    end else if (load_i) begin
      q_d = load_val_i;
    end else if (en_i) begin
      if (!at_limit) begin
        q_d = q_q + 1'b1;
      end else begin
        set_evt = 1'b1;
        if (!sat_mode_i) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end
      end
    end
    // A set event on the same edge as ovf_clr leaves the flag set.
    ovf_d = set_evt | (ovf_q & ~ovf_clr_i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign q_o    = q_q;
  assign tc_o   = at_limit;
  assign wrap_o = wrap_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_mod_up_counter.sv
// Bench for mod_up_counter: directed scenarios plus randomized traffic, checked
// against an integer reference model through an expected-response queue.
module tb_mod_up_counter;

  localparam int WIDTH = 4;
  localparam int W     = WIDTH + 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             clr_i = 1'b0, en_i = 1'b0, load_i = 1'b0;
  logic [WIDTH-1:0] load_val_i = '0, limit_i = '0;
  logic             sat_mode_i = 1'b0, ovf_clr_i = 1'b0;
  logic [WIDTH-1:0] q_o;
  logic             tc_o, wrap_o, ovf_o;

  int checks   = 0;
  int failures = 0;

  // Expected {q, wrap, ovf, tc} after each edge.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;

  // Reference model state in plain integers.
  int m_q   = 0;
  bit m_ovf = 1'b0;

  mod_up_counter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .clr_i(clr_i), .en_i(en_i), .load_i(load_i),
    .load_val_i(load_val_i), .limit_i(limit_i), .sat_mode_i(sat_mode_i),
    .ovf_clr_i(ovf_clr_i), .q_o(q_o), .tc_o(tc_o), .wrap_o(wrap_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: compares the registered outputs shortly after each active edge.
  always @(posedge clk) begin
    #1;
    if (!reset && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("q",    int'(q_o),    int'(e[W-1:3]));
      chk("wrap", int'(wrap_o), int'(e[2]));
      chk("ovf",  int'(ovf_o),  int'(e[1]));
      chk("tc",   int'(tc_o),   int'(e[0]));
    end
  end

  // One clock of stimulus: drive on the falling edge, check tc combinationally,
  // then advance the model and queue what the next rising edge must produce.
  task automatic cyc(input bit c, input bit l, input bit en, input int lv,
                     input bit oc, input int lim, input bit sat);
    int  nq;
    bit  nw;
    bit  evt;
    @(negedge clk);
    clr_i = c; load_i = l; en_i = en; load_val_i = WIDTH'(lv);
    ovf_clr_i = oc; limit_i = WIDTH'(lim); sat_mode_i = sat;
    #1;
    chk("tc_comb", int'(tc_o), int'(m_q >= lim));
    nq = m_q; nw = 1'b0; evt = 1'b0;
    if (c)                nq = 0;
    else if (l)           nq = lv;
    else if (en) begin
      if (m_q < lim)      nq = m_q + 1;
      else begin
        evt = 1'b1;
        if (!sat) begin nq = 0; nw = 1'b1; end
      end
    end
    if (evt)     m_ovf = 1'b1;
    else if (oc) m_ovf = 1'b0;
    m_q = nq;
    exp_q.push_back({WIDTH'(m_q), nw, m_ovf, bit'(m_q >= lim)});
  endtask

  // Asynchronous reset asserted between edges must clear outputs at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    clr_i = 1'b0; load_i = 1'b0; en_i = 1'b1; ovf_clr_i = 1'b0;
    #1;
    chk("rst_q",    int'(q_o),    0);
    chk("rst_wrap", int'(wrap_o), 0);
    chk("rst_ovf",  int'(ovf_o),  0);
    m_q = 0; m_ovf = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_hold_q", int'(q_o), 0);
    @(negedge clk);
    en_i = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-count, then a full count 1..9 and wrap.
    repeat (5) cyc(0, 0, 1, 0, 0, 9, 0);
    do_reset();
    repeat (11) cyc(0, 0, 1, 0, 0, 9, 0);

    // Saturation, ovf_clr, then set-wins-over-clear.
    cyc(1, 0, 0, 0, 0, 3, 1);
    repeat (5) cyc(0, 0, 1, 0, 0, 3, 1);
    cyc(0, 0, 0, 0, 1, 3, 1);
    cyc(0, 0, 1, 0, 1, 3, 1);

    // Priority clr > load > en.
    cyc(0, 1, 0, 4, 0, 9, 0);
    cyc(1, 1, 1, 7, 0, 9, 0);
    cyc(0, 1, 1, 7, 0, 9, 0);

    // Load above limit, wrap mode then saturation mode.
    cyc(0, 0, 0, 0, 1, 5, 0);
    cyc(0, 1, 0, 12, 0, 5, 0);
    cyc(0, 0, 1, 0, 0, 5, 0);
    cyc(0, 1, 0, 12, 1, 5, 1);
    cyc(0, 0, 1, 0, 0, 5, 1);
    cyc(0, 0, 1, 0, 0, 5, 1);

    // Full range wrap, then limit=0 with enable held.
    cyc(1, 0, 0, 0, 1, 15, 0);
    repeat (17) cyc(0, 0, 1, 0, 0, 15, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 1, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 1, 0, 0, 0, 1);

    // Enable gating, then a same-cycle limit change seen on tc.
    cyc(0, 1, 0, 2, 1, 9, 0);
    cyc(0, 0, 1, 0, 0, 9, 0);
    cyc(0, 0, 0, 0, 0, 9, 0);
    cyc(0, 0, 1, 0, 0, 9, 0);
    cyc(0, 0, 0, 0, 0, 9, 0);
    cyc(0, 0, 0, 0, 0, 4, 0);
    cyc(0, 0, 0, 0, 0, 9, 0);

    // Randomized traffic with occasional config changes and mid-cycle resets.
    begin
      int lim;
      bit sat;
      lim = 9; sat = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 15) == 0) lim = $urandom_range(0, 15);
        if ($urandom_range(0, 15) == 0) sat = ~sat;
        if ($urandom_range(0, 79) == 0) do_reset();
        cyc($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 15),
            $urandom_range(0, 9) == 0, lim, sat);
      end
    end

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_up_counter.md
Name: mod_up_counter

Overview:
- Loadable, programmable-modulus up counter. It complements the existing 4-bit down counter.
- Counts 0..limit, then wraps to 0 or saturates, selected at runtime.
- Provides a terminal-count output, a registered wrap pulse and a sticky overflow flag, for timers and event counting in the sequential lab designs.
- Outputs are taken straight from registers, except tc.

Parameters:
WIDTH, 4, counter width in bits; applies to q, load_val and limit.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
clr  input  1  synchronous clear of q to 0.
en  input  1  count enable; one increment per enabled cycle.
load  input  1  synchronous load of load_val into q.
load_val  input  WIDTH  value loaded when load=1.
limit  input  WIDTH  terminal value; count range is 0..limit inclusive.
sat_mode  input  1  0 = wrap to 0 after limit; 1 = hold at limit.
ovf_clr  input  1  synchronous clear of ovf.
q  output  WIDTH  current count (register).
tc  output  1  combinational; 1 when q >= limit.
wrap  output  1  registered one-cycle pulse; 1 in the cycle after q wrapped to 0.
ovf  output  1  sticky flag; set by a wrap or an increment blocked by saturation.

Behaviour:
- Interface: reset is asynchronous and active-high; clock is clk.
- Reset, whenever asserted and regardless of clk: q=0, wrap=0, ovf=0. Reset asserted mid-count takes effect immediately. After release, counting resumes from 0 on the first enabled edge.
- Priority each edge: clr > load > en > hold.
  - clr=1: q<=0, wrap<=0. ovf is unaffected, except through ovf_clr.
  - load=1 (clr=0): q<=load_val, wrap<=0. Values above limit are loaded unchanged.
  - en=1, q<limit: q<=q+1, wrap<=0.
  - en=1, q>=limit, sat_mode=0: q<=0, wrap<=1, ovf set.
  - en=1, q>=limit, sat_mode=1: q unchanged, wrap<=0, ovf set.
  - en=0: q holds, wrap<=0.
- Arithmetic: WIDTH-bit unsigned. The comparison q>=limit prevents q+1 from ever overflowing WIDTH bits. Example: limit=all-ones wraps from all-ones to 0 in wrap mode.
- tc = (q >= limit). It is purely combinational from q and limit and does not depend on en. A limit change is reflected in tc in the same cycle.
- Latency:
  - q changes one edge after the controlling input.
  - wrap is high exactly one cycle, the cycle in which q first reads 0 after a wrap.
  - Consecutive wraps give consecutive pulses; e.g. limit=0 with en held gives wrap=1 every cycle.
- ovf:
  - Set on any wrap or saturation-hold event.
  - Cleared when ovf_clr=1.
  - If ovf_clr and a set event occur on the same edge, set wins (ovf=1).
- limit=0: q stays 0 when enabled.
  - wrap mode: wrap and ovf assert every enabled cycle.
  - sat mode: ovf sets, and wrap stays 0.
- Load on the same edge as en: load wins, with no increment. A load of a value >= limit followed by en performs a wrap or saturation event on the next enabled edge.
- sat_mode changed while q==limit: takes effect on the next enabled edge.
- No X propagation: every register has a defined value after reset.

Test Plan:
- Tests use WIDTH=4.
1. Reset/count: assert reset mid-count at q=5 → q=0, wrap=0, ovf=0 immediately. Release with limit=9, sat_mode=0, en=1 → q=1..9, then 0. wrap=1 in the q=0 cycle only. tc=1 only at q=9. ovf=1 after the wrap.
2. Saturation: limit=3, sat_mode=1, en=1 from 0 → q=1,2,3,3,3. ovf sets on the first blocked edge, and wrap stays 0. Then ovf_clr=1 with en=0 → ovf=0. Then ovf_clr=1 together with en=1 at q=3 → ovf=1, since set wins.
3. Priority: q=4, drive clr=1, load=1, load_val=7, en=1 → q=0. Next edge with load=1, en=1 → q=7, with no increment.
4. Load above limit: limit=5, load 12 → tc=1 immediately after load. en=1, sat_mode=0 → q=0, wrap=1, ovf=1. Repeat with sat_mode=1 → q holds at 12, ovf=1.
5. Full range and limit=0: limit=15, en=1 → q wraps from 15 to 0 with a single wrap pulse. Then limit=0, en held 3 cycles → q=0 throughout, with wrap=1 for 3 consecutive cycles.
6. Enable gating: en toggled 1,0,1,0 from q=2 with limit=9 → q=3,3,4,4. wrap=0 throughout. tc tracks a limit change from 9 to 4 in the same cycle as the change.
